reg_context_sequencer: RTL and testbench

Multi-cycle sequencer that saves the eight general-purpose registers to memory or restores them from memory as a single operation, used by the LC-3 interrupt/TRAP path for context switches. It sits between the register file and the memory interface. During a save it drives the register file's SR1 read select. During a restore it drives the DR/LD_REG write port. It moves one word per memory handshake at ascending addresses from a programmable base.

---
 rtl/reg_context_sequencer_if.sv | 20 ++
 rtl/reg_context_sequencer.sv | 103 ++++++++++
 tb/tb_reg_context_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_context_sequencer_if.sv
// Memory-side request/response bundle for reg_context_sequencer.
// master = sequencer issuing requests, slave = memory answering them.
interface reg_context_sequencer_if;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_WData;
  logic        Mem_Ready;
  logic [15:0] Mem_RData;

  modport master (
    output Mem_Req, Mem_WE, Mem_Addr, Mem_WData,
    input  Mem_Ready, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_WE, Mem_Addr, Mem_WData,
    output Mem_Ready, Mem_RData
  );
endinterface

// File: rtl/reg_context_sequencer.sv
// Saves/restores R0..R7 to/from memory, one word per handshake.
// Define CTX_SKIP_R6_EN to leave R6 (stack pointer) out of the sequence.
module reg_context_sequencer (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic [15:0]             BaseAddr,
  input  logic [15:0]             SR1_Data,
  reg_context_sequencer_if.master mem,
  output logic                    Busy,
  output logic                    Done,
  output logic [2:0]              SR1,
  output logic [2:0]              DR,
  output logic                    LD_REG,
  output logic [15:0]             RF_In
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        mode_q;
  logic [15:0] base_q;
  logic [2:0]  idx_nxt;
  logic        last;

`ifdef CTX_SKIP_R6_EN
  assign idx_nxt = (idx_q == 3'd5) ? 3'd7 : idx_q + 3'd1;
`else
  assign idx_nxt = idx_q + 3'd1;
`endif
  assign last = (idx_q == 3'd7);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      mode_q  <= 1'b0;
      base_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && Start) begin
        mode_q <= Mode;
        base_q <= BaseAddr;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    Busy          = 1'b0;
    Done          = 1'b0;
    SR1           = 3'd0;
    DR            = 3'd0;
    LD_REG        = 1'b0;
    RF_In         = 16'h0000;
    mem.Mem_Req   = 1'b0;
    mem.Mem_WE    = 1'b0;
    mem.Mem_Addr  = 16'h0000;
    mem.Mem_WData = 16'h0000;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_REQ;
          idx_d   = 3'd0;
        end
      end
      S_REQ: begin
        Busy         = 1'b1;
        mem.Mem_Req  = 1'b1;
        mem.Mem_WE   = ~mode_q;
        mem.Mem_Addr = base_q + {13'd0, idx_q};
        if (mode_q) begin
          // Load lands on the same edge that completes the read
          LD_REG = mem.Mem_Ready;
          DR     = idx_q;
          RF_In  = mem.Mem_RData;
        end else begin
          SR1           = idx_q;
          mem.Mem_WData = SR1_Data;
        end
        if (mem.Mem_Ready) begin
          if (last) state_d = S_DONE;
          else      idx_d   = idx_nxt;
        end
      end
      S_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Directed bench for reg_context_sequencer with a register-file and memory model.
// Honours CTX_SKIP_R6_EN when the design is built with it.
module tb_reg_context_sequencer;

`ifdef CTX_SKIP_R6_EN
  localparam int NX   = 7;
  localparam bit SKIP = 1'b1;
`else
  localparam int NX   = 8;
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset, Start, Mode;
  logic [15:0] BaseAddr, SR1_Data;
  logic        Busy, Done, LD_REG;
  logic [2:0]  SR1, DR;
  logic [15:0] RF_In;

  reg_context_sequencer_if bus();

  logic [15:0] rf [8];
  logic [15:0] mem [65536];
  logic [15:0] base_tb;
  int ld_cnt, ld_r6, a6_cnt, done_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_context_sequencer dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .BaseAddr(BaseAddr), .SR1_Data(SR1_Data), .mem(bus),
    .Busy(Busy), .Done(Done), .SR1(SR1), .DR(DR),
    .LD_REG(LD_REG), .RF_In(RF_In)
  );

  assign SR1_Data      = rf[SR1];
  assign bus.Mem_RData = mem[bus.Mem_Addr];

  always @(posedge clk) begin
    if (LD_REG) begin
      rf[DR] <= RF_In;
      ld_cnt++;
      if (DR == 3'd6) ld_r6++;
    end
    if (bus.Mem_Req && bus.Mem_Ready && bus.Mem_WE)
      mem[bus.Mem_Addr] <= bus.Mem_WData;
    if (bus.Mem_Req && bus.Mem_Addr == base_tb + 16'd6) a6_cnt++;
    if (Done) done_cnt++;
  end

  function automatic int xidx(int k);
    return (SKIP && k >= 6) ? k + 1 : k;
  endfunction

  task automatic clr();
    ld_cnt = 0; ld_r6 = 0; a6_cnt = 0; done_cnt = 0;
  endtask

  task automatic test_reset();
    Reset = 1; Start = 1; Mode = 1; BaseAddr = 16'h1234;
    bus.Mem_Ready = 1; base_tb = 16'h1234;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 0 || Done !== 0 || bus.Mem_Req !== 0 || LD_REG !== 0 ||
        bus.Mem_Addr !== 0 || bus.Mem_WE !== 0 || SR1 !== 0 || DR !== 0 ||
        RF_In !== 0 || bus.Mem_WData !== 0) begin
      n_bad++;
      $display("FAIL reset busy=%b done=%b req=%b ld=%b addr=%h we=%b required all 0",
               Busy, Done, bus.Mem_Req, LD_REG, bus.Mem_Addr, bus.Mem_WE);
    end
    @(posedge clk); #1;
    Reset = 0; Start = 0;
    clr();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (Busy !== 0 || bus.Mem_Req !== 0) begin
        n_bad++;
        $display("FAIL idle_ready busy=%b req=%b required 0 0", Busy, bus.Mem_Req);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_save();
    int x;
    base_tb = 16'h3000;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'h1110 + 16'(i);
      mem[16'h3000 + i] = 16'h0000;
    end
    clr();
    bus.Mem_Ready = 1; Mode = 0; BaseAddr = 16'h3000; Start = 1;
    @(posedge clk); #1;
    Start = 0; Mode = 1; BaseAddr = 16'h0000;
    for (int c = 1; c <= NX + 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c <= NX) begin
        x = xidx(c - 1);
        if (bus.Mem_Req !== 1 || bus.Mem_WE !== 1 ||
            bus.Mem_Addr !== 16'h3000 + 16'(x) ||
            bus.Mem_WData !== 16'h1110 + 16'(x) ||
            SR1 !== 3'(x) || LD_REG !== 0 || Done !== 0) begin
          n_bad++;
          $display("FAIL save c=%0d req=%b we=%b addr=%h wdata=%h sr1=%0d ld=%b, required addr=%h wdata=%h sr1=%0d",
                   c, bus.Mem_Req, bus.Mem_WE, bus.Mem_Addr, bus.Mem_WData,
                   SR1, LD_REG, 16'h3000 + 16'(x), 16'h1110 + 16'(x), x);
        end
      end else if (c == NX + 1) begin
        if (Done !== 1 || Busy !== 1 || bus.Mem_Req !== 0) begin
          n_bad++;
          $display("FAIL save_done c=%0d done=%b busy=%b req=%b required 1 1 0",
                   c, Done, Busy, bus.Mem_Req);
        end
      end else begin
        if (Done !== 0 || Busy !== 0) begin
          n_bad++;
          $display("FAIL save_idle done=%b busy=%b required 0 0", Done, Busy);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[16'h3000 + i] !== ((SKIP && i == 6) ? 16'h0000 : 16'h1110 + 16'(i))) begin
        n_bad++;
        $display("FAIL save_mem i=%0d got=%h", i, mem[16'h3000 + i]);
      end
    end
    n_cmp++;
    if (ld_cnt !== 0 || done_cnt !== 1 || a6_cnt !== (SKIP ? 0 : 1)) begin
      n_bad++;
      $display("FAIL save_counts ld=%0d done=%0d a6=%0d required 0 1 %0d",
               ld_cnt, done_cnt, a6_cnt, SKIP ? 0 : 1);
    end
  endtask

  task automatic test_restore();
    int x;
    base_tb = 16'h4000;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'h0000;
      mem[16'h4000 + i] = 16'hA000 + 16'(i);
    end
    clr();
    bus.Mem_Ready = 1; Mode = 1; BaseAddr = 16'h4000; Start = 1;
    @(posedge clk); #1;
    Start = 0; Mode = 0;
    for (int c = 1; c <= NX + 1; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c <= NX) begin
        x = xidx(c - 1);
        if (bus.Mem_Req !== 1 || bus.Mem_WE !== 0 ||
            bus.Mem_Addr !== 16'h4000 + 16'(x) || LD_REG !== 1 ||
            DR !== 3'(x) || RF_In !== 16'hA000 + 16'(x) ||
            bus.Mem_WData !== 0 || SR1 !== 0) begin
          n_bad++;
          $display("FAIL restore c=%0d addr=%h ld=%b dr=%0d rf_in=%h we=%b, required addr=%h dr=%0d rf_in=%h",
                   c, bus.Mem_Addr, LD_REG, DR, RF_In, bus.Mem_WE,
                   16'h4000 + 16'(x), x, 16'hA000 + 16'(x));
        end
      end else if (Done !== 1 || LD_REG !== 0) begin
        n_bad++;
        $display("FAIL restore_done done=%b ld=%b required 1 0", Done, LD_REG);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== ((SKIP && i == 6) ? 16'h0000 : 16'hA000 + 16'(i))) begin
        n_bad++;
        $display("FAIL restore_rf r%0d got=%h", i, rf[i]);
      end
    end
    n_cmp++;
    if (ld_cnt !== NX || ld_r6 !== (SKIP ? 0 : 1) || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL restore_counts ld=%0d r6=%0d done=%0d required %0d %0d 1",
               ld_cnt, ld_r6, done_cnt, NX, SKIP ? 0 : 1);
    end
  endtask

  task automatic test_stall();
    int x;
    base_tb = 16'h3000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);
    clr();
    Mode = 0; BaseAddr = 16'h3000; Start = 1;
    @(posedge clk); #1;
    Start = 0;
    for (int c = 1; c <= NX + 4; c++) begin
      bus.Mem_Ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      n_cmp++;
      if (c <= NX + 3) begin
        x = (c < 3) ? c - 1 : (c <= 5) ? 2 : xidx(c - 4);
        if (bus.Mem_Req !== 1 || bus.Mem_Addr !== 16'h3000 + 16'(x) ||
            bus.Mem_WData !== 16'h1110 + 16'(x) || bus.Mem_WE !== 1) begin
          n_bad++;
          $display("FAIL stall c=%0d addr=%h wdata=%h, required addr=%h wdata=%h",
                   c, bus.Mem_Addr, bus.Mem_WData,
                   16'h3000 + 16'(x), 16'h1110 + 16'(x));
        end
      end else if (Done !== 1) begin
        n_bad++;
        $display("FAIL stall_done c=%0d done=%b required 1", c, Done);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_cnt !== 1 || Busy !== 0) begin
      n_bad++;
      $display("FAIL stall_end done_cnt=%0d busy=%b required 1 0", done_cnt, Busy);
    end
  endtask

  task automatic test_wrap();
    int x;
    logic [15:0] ea;
    base_tb = 16'hFFFE;
    for (int i = 0; i < 8; i++) begin
      ea = 16'hFFFE + 16'(i);
      mem[ea] = 16'hB000 + 16'(i);
      rf[i] = 16'h0000;
    end
    clr();
    bus.Mem_Ready = 1; Mode = 1; BaseAddr = 16'hFFFE; Start = 1;
    @(posedge clk); #1;
    Start = 0;
    for (int c = 1; c <= NX + 1; c++) begin
      if (c == 4) begin
        Start = 1; Mode = 0; BaseAddr = 16'h1234;
      end else begin
        Start = 0;
      end
      @(negedge clk);
      n_cmp++;
      if (c <= NX) begin
        x = xidx(c - 1);
        ea = 16'hFFFE + 16'(x);
        if (bus.Mem_Addr !== ea || LD_REG !== 1 || bus.Mem_WE !== 0 ||
            RF_In !== 16'hB000 + 16'(x)) begin
          n_bad++;
          $display("FAIL wrap c=%0d addr=%h ld=%b we=%b rf_in=%h, required addr=%h",
                   c, bus.Mem_Addr, LD_REG, bus.Mem_WE, RF_In, ea);
        end
      end else if (Done !== 1) begin
        n_bad++;
        $display("FAIL wrap_done done=%b required 1", Done);
      end
      @(posedge clk); #1;
    end
    Start = 0;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 0 || rf[1] !== 16'hB001 || rf[2] !== 16'hB002 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL wrap_end busy=%b r1=%h r2=%h done=%0d required 0 b001 b002 1",
               Busy, rf[1], rf[2], done_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    base_tb = 16'h4000;
    for (int i = 0; i < 8; i++) begin
      mem[16'h4000 + i] = 16'hC000 + 16'(i);
      rf[i] = 16'h5550 + 16'(i);
    end
    clr();
    bus.Mem_Ready = 1; Mode = 1; BaseAddr = 16'h4000; Start = 1;
    @(posedge clk); #1;
    Start = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) Reset = 1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    Reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (Busy !== 0 || bus.Mem_Req !== 0 || Done !== 0 || LD_REG !== 0) begin
        n_bad++;
        $display("FAIL reset_mid_idle busy=%b req=%b done=%b ld=%b required 0",
                 Busy, bus.Mem_Req, Done, LD_REG);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== ((i <= 4) ? 16'hC000 + 16'(i) : 16'h5550 + 16'(i))) begin
        n_bad++;
        $display("FAIL reset_mid_rf r%0d got=%h", i, rf[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 0 || ld_cnt !== 5) begin
      n_bad++;
      $display("FAIL reset_mid_counts done=%0d ld=%0d required 0 5", done_cnt, ld_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    base_tb = 16'h3000;
    clr();
    bus.Mem_Ready = 1; Mode = 0; BaseAddr = 16'h3000; Start = 1;
    @(posedge clk); #1;
    Start = 0;
    seen = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      seen = (Done === 1);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL b2b_timeout done never seen");
    end
    Start = 1; Mode = 1; BaseAddr = 16'h4000;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 0) begin
      n_bad++;
      $display("FAIL b2b_idle busy=%b required 0", Busy);
    end
    @(posedge clk); #1;
    Start = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.Mem_Req !== 1 || bus.Mem_WE !== 0 || bus.Mem_Addr !== 16'h4000) begin
      n_bad++;
      $display("FAIL b2b_start req=%b we=%b addr=%h required 1 0 4000",
               bus.Mem_Req, bus.Mem_WE, bus.Mem_Addr);
    end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      seen = (Busy === 0);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL b2b_end_timeout busy stuck");
    end
  endtask

  initial begin
    Reset = 0; Start = 0; Mode = 0; BaseAddr = 0;
    bus.Mem_Ready = 0; base_tb = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    clr();
    test_reset();
    test_save();
    test_restore();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
